// File: rtl/zero_count_frame_accum.sv
// Frame zero-bit accumulator: counts 0 bits of each accepted byte, sums them over
// a last-terminated frame and presents total, byte count and flags on a held handshake.
module zero_count_frame_accum #(
    parameter int ACC_W  = 16,
    parameter int CNT_W  = 12,
    parameter int THRESH = 100
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [7:0]       in_data_i,
    input  logic             in_last_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [ACC_W-1:0] out_zeros_o,
    output logic [CNT_W-1:0] out_bytes_o,
    output logic             out_over_o,
    output logic             out_sat_o,
    output logic             busy_o
);

    // state | meaning
    // IDLE  | no byte of the current frame accepted yet
    // ACCUM | frame in progress, acc/cnt hold the running totals
    // HOLD  | result presented, waiting for out_ready_i
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_zeros_q, out_zeros_d;
    logic [CNT_W-1:0] out_bytes_q, out_bytes_d;
    logic             out_over_q, out_over_d;
    logic             out_sat_q, out_sat_d;

    logic [3:0]       zc;
    logic             accept;
    logic [ACC_W:0]   acc_sum;
    logic [CNT_W:0]   cnt_sum;
    logic [ACC_W-1:0] acc_clamp;
    logic [CNT_W-1:0] cnt_clamp;
    logic             sat_now;
    logic             over_now;

    always_comb begin
        zc = 4'd0;
        for (int i = 0; i < 8; i++) begin
            zc = zc + {3'b000, ~in_data_i[i]};
        end
    end

    assign in_ready_o = (state_q != S_HOLD);
    assign accept     = in_valid_i & in_ready_o;

    // acc/cnt are zero whenever IDLE, so the same adder serves the first byte.
    assign acc_sum   = {1'b0, acc_q} + (ACC_W+1)'(zc);
    assign cnt_sum   = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign acc_clamp = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
    assign cnt_clamp = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    assign sat_now   = acc_sum[ACC_W] | cnt_sum[CNT_W];
    assign over_now  = (32'(acc_clamp) > $unsigned(THRESH));

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        out_zeros_d = out_zeros_q;
        out_bytes_d = out_bytes_q;
        out_over_d  = out_over_q;
        out_sat_d   = out_sat_q;
        if (state_q == S_HOLD) begin
            if (out_ready_i) begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        end else if (accept) begin
            if (in_last_i) begin
                out_valid_d = 1'b1;
                out_zeros_d = acc_clamp;
                out_bytes_d = cnt_clamp;
                out_over_d  = over_now;
                out_sat_d   = sat_q | sat_now;
                acc_d       = '0;
                cnt_d       = '0;
                sat_d       = 1'b0;
                state_d     = S_HOLD;
            end else begin
                acc_d   = acc_clamp;
                cnt_d   = cnt_clamp;
                sat_d   = sat_q | sat_now;
                state_d = S_ACCUM;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_zeros_q <= '0;
            out_bytes_q <= '0;
            out_over_q  <= 1'b0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            out_zeros_q <= out_zeros_d;
            out_bytes_q <= out_bytes_d;
            out_over_q  <= out_over_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_zeros_o = out_zeros_q;
    assign out_bytes_o = out_bytes_q;
    assign out_over_o  = out_over_q;
    assign out_sat_o   = out_sat_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_zero_count_frame_accum.sv
// Bench for zero_count_frame_accum: a default instance and a narrow saturating
// instance, driven by directed and random frames against a frame-level model.
module tb_zero_count_frame_accum;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_ready;
    int         sel;

    logic        rdy_a, ov_a, over_a, sat_a, busy_a;
    logic [15:0] oz_a;
    logic [11:0] ob_a;
    logic        rdy_b, ov_b, over_b, sat_b, busy_b;
    logic [3:0]  oz_b;
    logic [1:0]  ob_b;

    logic        rdy, ov, over, sat, busy;
    logic [15:0] oz;
    logic [11:0] ob;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] fq[$];

    always #5 clk = ~clk;

    zero_count_frame_accum u_dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid && sel == 0), .in_ready_o(rdy_a),
        .in_data_i(in_data), .in_last_i(in_last),
        .out_valid_o(ov_a), .out_ready_i(out_ready && sel == 0),
        .out_zeros_o(oz_a), .out_bytes_o(ob_a),
        .out_over_o(over_a), .out_sat_o(sat_a), .busy_o(busy_a)
    );

    zero_count_frame_accum #(.ACC_W(4), .CNT_W(2)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid && sel == 1), .in_ready_o(rdy_b),
        .in_data_i(in_data), .in_last_i(in_last),
        .out_valid_o(ov_b), .out_ready_i(out_ready && sel == 1),
        .out_zeros_o(oz_b), .out_bytes_o(ob_b),
        .out_over_o(over_b), .out_sat_o(sat_b), .busy_o(busy_b)
    );

    assign rdy  = (sel == 1) ? rdy_b  : rdy_a;
    assign ov   = (sel == 1) ? ov_b   : ov_a;
    assign over = (sel == 1) ? over_b : over_a;
    assign sat  = (sel == 1) ? sat_b  : sat_a;
    assign busy = (sel == 1) ? busy_b : busy_a;
    assign oz   = (sel == 1) ? {12'd0, oz_b} : oz_a;
    assign ob   = (sel == 1) ? {10'd0, ob_b} : ob_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Frame result from the rules: zeros summed over the frame, clamped to the widths.
    function automatic void model(input int d, output logic [31:0] ez, output logic [31:0] eb,
                                  output logic [31:0] eo, output logic [31:0] es);
        int tz   = 0;
        int n    = fq.size();
        int maxa = (d == 1) ? 15 : 65535;
        int maxc = (d == 1) ? 3 : 4095;
        foreach (fq[i]) tz += 8 - $countones(fq[i]);
        es = ((tz > maxa) || (n > maxc)) ? 1 : 0;
        ez = (tz > maxa) ? maxa : tz;
        eb = (n > maxc) ? maxc : n;
        eo = (ez > 100) ? 1 : 0;
    endfunction

    // Called just after the edge that accepted the last byte.
    task automatic check_result(input int d, input int hold_cyc, input bit offer);
        logic [31:0] ez, eb, eo, es;
        model(d, ez, eb, eo, es);
        @(negedge clk);
        in_valid = offer;
        in_data  = 8'h3C;
        in_last  = 1'b1;
        chk("valid_after_last", ov, 1);
        chk("zeros", oz, ez);
        chk("bytes", ob, eb);
        chk("over", over, eo);
        chk("sat", sat, es);
        chk("ready_in_hold", rdy, 0);
        chk("busy_in_hold", busy, 1);
        for (int k = 0; k < hold_cyc; k++) begin
            @(negedge clk);
            chk("hold_valid", ov, 1);
            chk("hold_zeros", oz, ez);
            chk("hold_ready", rdy, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_drop", ov, 0);
        chk("ready_back", rdy, 1);
        chk("busy_idle", busy, 0);
        chk("zeros_kept", oz, ez);
        chk("bytes_kept", ob, eb);
    endtask

    // gap < 0 selects random idle cycles (0..2) between bytes.
    task automatic run_frame(input int d, input int gap, input int hold_cyc, input bit offer);
        sel = d;
        for (int i = 0; i < fq.size(); i++) begin
            int g;
            int w;
            g = (i == 0) ? 0 : ((gap < 0) ? int'($urandom_range(2, 0)) : gap);
            for (int k = 0; k < g; k++) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                in_last  = 1'($urandom);
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = fq[i];
            in_last  = (i == fq.size() - 1);
            w = 0;
            while (!rdy && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (w >= 20) chk("ready_timeout", rdy, 1);
            @(posedge clk);
        end
        check_result(d, hold_cyc, offer);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
        out_ready = 1'b0; sel = 0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sel = d;
            #1;
            chk("rst_valid", ov, 0);
            chk("rst_zeros", oz, 0);
            chk("rst_bytes", ob, 0);
            chk("rst_over", over, 0);
            chk("rst_sat", sat, 0);
            chk("rst_busy", busy, 0);
        end
        sel = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", rdy, 1);

        fq = '{8'h00, 8'hFF, 8'h0F};
        run_frame(0, 0, 0, 0);

        fq = '{8'h00};
        run_frame(0, 0, 1, 0);

        fq = '{8'hA5, 8'h81};
        run_frame(0, 3, 5, 1);
        fq = '{8'h3C};
        @(posedge clk);
        check_result(0, 0, 0);

        fq.delete();
        repeat (12) fq.push_back(8'h00);
        fq.push_back(8'h0F);
        run_frame(0, 0, 0, 0);
        fq[12] = 8'h07;
        run_frame(0, 0, 0, 0);

        fq = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(1, 0, 0, 0);
        fq = '{8'hFF};
        run_frame(1, 0, 0, 0);

        sel = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h00; in_last = 1'b0;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", ov, 0);
        chk("midrst_zeros", oz, 0);
        chk("midrst_bytes", ob, 0);
        chk("midrst_over", over, 0);
        chk("midrst_busy", busy, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("midrst_novalid", ov, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_novalid", ov, 0);
        fq = '{8'hFE};
        run_frame(0, 0, 0, 0);

        for (int t = 0; t < 30; t++) begin
            int n;
            fq.delete();
            n = $urandom_range(7, 1);
            for (int i = 0; i < n; i++)
                fq.push_back(($urandom_range(3, 0) == 0) ? 8'h00 : 8'($urandom));
            run_frame(int'($urandom_range(1, 0)), -1, int'($urandom_range(3, 0)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/zero_count_frame_accum.md
Name: zero_count_frame_accum

Overview:
- Downstream consumer of the per-byte zero counter.
- Accepts a byte stream framed by a last flag, using a valid/ready handshake.
- Counts the zero bits in every accepted byte and accumulates them over the frame.
- Presents the frame total, the byte count and a threshold flag on a held output handshake, for the detection/statistics stage behind it.

Parameters:
- ACC_W, 16, width of the frame zero-total accumulator and of out_zeros.
- CNT_W, 12, width of the frame byte counter and of out_bytes.
- THRESH, 100, out_over asserts when the frame zero-total is strictly greater than this value.

Ports:
- clk  input  1  system clock; all state is updated on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data/in_last are valid.
- in_ready  output  1  block can accept a byte this cycle.
- in_data  input  8  byte to count.
- in_last  input  1  accepted byte is the final byte of its frame.
- out_valid  output  1  frame result is valid and held.
- out_ready  input  1  consumer takes the result.
- out_zeros  output  ACC_W  zero-bit total of the frame.
- out_bytes  output  CNT_W  number of bytes in the frame.
- out_over  output  1  out_zeros > THRESH.
- out_sat  output  1  accumulator or byte counter saturated during the frame.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE, accumulator = 0, byte counter = 0, sat flag = 0.
  - out_valid = 0, out_zeros = 0, out_bytes = 0, out_over = 0, out_sat = 0, busy = 0.
  - in_ready follows state and is therefore 1 from the first cycle after reset is released.
- Handshake and counting:
  - accept = in_valid & in_ready.
  - in_ready = (state != HOLD); it is combinational from state only, not from out_ready.
  - Bytes that are not accepted have no effect, and in_data is ignored on those cycles.
  - Per-byte zero count zc = number of 0 bits in in_data, range 0..8; it is combinational inside the block.
- Arithmetic:
  - sum = acc + zc, computed with one extra bit. If sum exceeds 2^ACC_W-1, the result clamps to all-ones and the sat flag is set.
  - The byte counter works the same way: it increments by 1 per accepted byte, clamps at 2^CNT_W-1 and sets the sat flag.
  - The sat flag is sticky for the frame.
- States:
  - IDLE (no byte of the current frame accepted yet):
    - accept & !in_last: acc <= zc, cnt <= 1, go to ACCUM.
    - accept & in_last: load outputs with zeros = zc and bytes = 1, go to HOLD.
  - ACCUM:
    - accept & !in_last: acc <= sum, cnt <= cnt+1.
    - accept & in_last: load outputs with the saturated sum and cnt+1, go to HOLD.
    - Idle cycles (in_valid = 0) hold all state.
  - HOLD:
    - out_valid = 1; out_zeros, out_bytes, out_over and out_sat are stable.
    - On out_valid & out_ready: out_valid <= 0, go to IDLE.
    - in_ready returns to 1 on the next cycle; there is no same-cycle bypass, so there is exactly one bubble between frames.
- Output load, on the cycle the last byte is accepted:
  - out_zeros, out_bytes, out_over (final total > THRESH) and out_sat (sat flag or saturation on this byte) are registered.
  - out_valid rises on the following clock edge, so latency is 1 cycle from the last-byte accept to out_valid.
  - The internal accumulator, counter and sat flag clear in the same edge.
- Output hold: the output registers keep their values after the handshake until the next load. Only out_valid deasserts.
- Reset mid-frame or mid-HOLD: everything returns to the reset values immediately, and a partial frame is discarded with no output.
- out_over compares the possibly saturated out_zeros value.

Test Plan:
- Frame 0x00, 0xFF, 0x0F(last), back-to-back, with out_ready = 1 -> out_valid is high 1 cycle after the last accept with out_zeros = 12, out_bytes = 3, out_over = 0, out_sat = 0; in_ready is 0 for exactly one cycle, then 1.
- Single byte 0x00 with last from IDLE -> out_zeros = 8, out_bytes = 1; state goes IDLE->HOLD directly; busy = 1 during HOLD.
- Frame 0xA5, gap of 3 cycles with in_valid = 0, then 0x81(last), and out_ready held low for 5 cycles:
  - result is out_zeros = 10, out_bytes = 2;
  - outputs stay stable and in_ready = 0 while a new byte is offered and not accepted;
  - on out_ready = 1, out_valid drops next cycle and the offered byte is accepted one cycle later.
- Threshold checks with default THRESH:
  - 12x 0x00 plus 0x0F(last) -> 100, out_over = 0;
  - 12x 0x00 plus 0x07(last) -> 101, out_over = 1.
- Instance with ACC_W = 4, CNT_W = 2, frame of 5x 0x00 -> out_zeros = 15, out_bytes = 3, out_sat = 1; the next frame 0xFF(last) gives out_zeros = 0, out_bytes = 1, out_sat = 0.
- Two bytes 0x00 accepted, then rst_n pulsed low mid-frame:
  - all outputs read 0 during reset and out_valid never rises;
  - the next frame 0xFE(last) gives out_zeros = 1, out_bytes = 1.
